debounce_controller: RTL and testbench

Multi-channel input conditioner for asynchronous off-chip signals such as buttons, switches and external interrupt lines. Each channel passes through a `synchronizer` instance, then a per-channel debounce state machine driven by a saturating counter. The block emits a clean level, single-cycle edge pulses and sticky interrupt-pending bits. It sits between the board pins and the GPIO/interrupt peripherals.

---
 rtl/debounce_controller.sv | 200 ++++++++++++++++++++
 tb/tb_debounce_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_controller.sv
// Multi-channel input conditioner for asynchronous off-chip signals.
// Each channel is synchronized, then filtered by a small debounce FSM with a
// saturating run counter. The block produces a clean level, single-cycle
// edge pulses and sticky interrupt-pending bits that feed one shared irq line.

// Plain flop chain that brings an asynchronous input into the clk_i domain.
module synchronizer #(
    parameter int FLOP_NUMBER = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d,
    output logic q
);

    logic [FLOP_NUMBER-1:0] ff_q;

    // Shift the raw input through the chain; the last flop is the usable sample.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, exactly like hardware.
        if (!rst_n_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[FLOP_NUMBER-2:0], d};
        end
    end

    assign q = ff_q[FLOP_NUMBER-1];

endmodule

module debounce_controller #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [CHANNELS-1:0]    async_i,
    input  logic                   enable_i,
    input  logic [COUNT_WIDTH-1:0] threshold_i,
    input  logic [CHANNELS-1:0]    rise_irq_en_i,
    input  logic [CHANNELS-1:0]    fall_irq_en_i,
    input  logic [CHANNELS-1:0]    irq_clear_i,
    output logic [CHANNELS-1:0]    level_o,
    output logic [CHANNELS-1:0]    rise_o,
    output logic [CHANNELS-1:0]    fall_o,
    output logic [CHANNELS-1:0]    pending_o,
    output logic                   irq_o
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q [CHANNELS];
    state_t                 state_d [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_d [CHANNELS];

    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    rise_q;
    logic [CHANNELS-1:0]    rise_d;
    logic [CHANNELS-1:0]    fall_q;
    logic [CHANNELS-1:0]    fall_d;
    logic [CHANNELS-1:0]    pending_q;
    logic [CHANNELS-1:0]    pending_d;
    logic [COUNT_WIDTH-1:0] thr_eff;

    // Count of consecutive differing samples; holds at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + COUNT_ONE;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        synchronizer #(
            .FLOP_NUMBER(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .d      (async_i[g]),
            .q      (s[g])
        );
    end

    // A threshold of zero would commit on nothing; treat it as one sample.
    assign thr_eff = (threshold_i == '0) ? COUNT_ONE : threshold_i;

    // Per-channel debounce decision: next state, next count and edge pulses.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            unique case (state_q[i])
                STABLE_LOW: begin
                    if (enable_i && s[i]) begin
                        if (COUNT_ONE >= thr_eff) begin
                            state_d[i] = STABLE_HIGH;
                            count_d[i] = '0;
                            rise_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = WAIT_HIGH;
                            count_d[i] = COUNT_ONE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!enable_i || !s[i]) begin
                        state_d[i] = STABLE_LOW;
                        count_d[i] = '0;
                    end else if (sat_inc(count_q[i]) >= thr_eff) begin
                        state_d[i] = STABLE_HIGH;
                        count_d[i] = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = sat_inc(count_q[i]);
                    end
                end
                STABLE_HIGH: begin
                    if (enable_i && !s[i]) begin
                        if (COUNT_ONE >= thr_eff) begin
                            state_d[i] = STABLE_LOW;
                            count_d[i] = '0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = WAIT_LOW;
                            count_d[i] = COUNT_ONE;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!enable_i || s[i]) begin
                        state_d[i] = STABLE_HIGH;
                        count_d[i] = '0;
                    end else if (sat_inc(count_q[i]) >= thr_eff) begin
                        state_d[i] = STABLE_LOW;
                        count_d[i] = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = sat_inc(count_q[i]);
                    end
                end
                default: begin
                    state_d[i] = STABLE_LOW;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    // Sticky pending: a new event in the same cycle as a clear keeps the bit set.
    always_comb begin
        pending_d = (pending_q & ~irq_clear_i)
                  | (rise_q & rise_irq_en_i)
                  | (fall_q & fall_irq_en_i);
    end

    // Debounce state, counters, edge pulses and pending bits.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= STABLE_LOW;
                count_q[i] <= '0;
            end
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    // The debounced level is high while the channel sits on the high side.
    always_comb begin
        level_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level_o[i] = (state_q[i] == STABLE_HIGH) || (state_q[i] == WAIT_LOW);
        end
    end

    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pending_q;
    assign irq_o     = |pending_q;

endmodule

// File: tb/tb_debounce_controller.sv
// Self-checking bench for debounce_controller. A behavioural model tracks, per
// channel, the delayed sample stream and the length of the current run of
// samples that disagree with the debounced level; outputs are compared every
// cycle, plus directed latency and corner-case checks.
module tb_debounce_controller;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int CW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [CH-1:0] async_i;
    logic          enable_i;
    logic [CW-1:0] threshold_i;
    logic [CH-1:0] rise_irq_en_i;
    logic [CH-1:0] fall_irq_en_i;
    logic [CH-1:0] irq_clear_i;
    logic [CH-1:0] level_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic [CH-1:0] pending_o;
    logic          irq_o;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [CH-1:0]   lvl_m;
    logic [CH-1:0]   rise_m;
    logic [CH-1:0]   fall_m;
    logic [CH-1:0]   pend_m;
    int unsigned     run_m  [CH];
    logic [SYNC-1:0] sync_m [CH];

    debounce_controller #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SYNC),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .async_i      (async_i),
        .enable_i     (enable_i),
        .threshold_i  (threshold_i),
        .rise_irq_en_i(rise_irq_en_i),
        .fall_irq_en_i(fall_irq_en_i),
        .irq_clear_i  (irq_clear_i),
        .level_o      (level_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .pending_o    (pending_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: inputs seen at this edge, model advances.
    task automatic model_step();
        int unsigned te;
        logic        smp;
        te = (threshold_i == '0) ? 1 : int'(threshold_i);
        if (!rst_n_i) begin
            lvl_m  = '0;
            rise_m = '0;
            fall_m = '0;
            pend_m = '0;
            for (int i = 0; i < CH; i++) begin
                run_m[i]  = 0;
                sync_m[i] = '0;
            end
        end else begin
            pend_m = (pend_m & ~irq_clear_i) | (rise_m & rise_irq_en_i) | (fall_m & fall_irq_en_i);
            rise_m = '0;
            fall_m = '0;
            for (int i = 0; i < CH; i++) begin
                smp = sync_m[i][SYNC-1];
                if (enable_i && (smp != lvl_m[i])) begin
                    run_m[i] = (run_m[i] == MAXC) ? MAXC : run_m[i] + 1;
                    if (run_m[i] >= te) begin
                        if (smp) rise_m[i] = 1'b1;
                        else     fall_m[i] = 1'b1;
                        lvl_m[i] = smp;
                        run_m[i] = 0;
                    end
                end else begin
                    run_m[i] = 0;
                end
                sync_m[i] = {sync_m[i][SYNC-2:0], async_i[i]};
            end
        end
    endtask

    task automatic compare_all();
        check("level",   32'(level_o),   32'(lvl_m));
        check("rise",    32'(rise_o),    32'(rise_m));
        check("fall",    32'(fall_o),    32'(fall_m));
        check("pending", 32'(pending_o), 32'(pend_m));
        check("irq",     32'(irq_o),     32'(|pend_m));
    endtask

    // Advance one clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    // Ticks until the requested edge pulse is seen on channel ch; n=-1 on timeout.
    task automatic wait_edge(input int ch, input bit rising, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (rising ? rise_o[ch] : fall_o[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_n_i       = 1'b0;
        async_i       = '0;
        enable_i      = 1'b1;
        threshold_i   = CW'(5);
        rise_irq_en_i = '0;
        fall_irq_en_i = '0;
        irq_clear_i   = '0;
        lvl_m  = '0;
        rise_m = '0;
        fall_m = '0;
        pend_m = '0;
        for (int i = 0; i < CH; i++) begin
            run_m[i]  = 0;
            sync_m[i] = '0;
        end

        // Reset, then a quiet stretch.
        repeat (3) tick();
        check("reset_level", 32'(level_o), 32'h0);
        check("reset_irq",   32'(irq_o),   32'h0);
        rst_n_i = 1'b1;
        repeat (100) tick();
        check("quiet_level", 32'(level_o), 32'h0);

        // Clean rise on ch0 with threshold 5: sync stages plus N edges.
        async_i[0] = 1'b1;
        wait_edge(0, 1'b1, 50, n);
        check("clean_rise_latency", 32'(n), 32'd7);
        check("clean_rise_others",  32'(level_o), 32'b0001);

        // Glitch of 3 cycles on ch1 with threshold 8 is rejected.
        threshold_i = CW'(8);
        async_i[1]  = 1'b1;
        repeat (3) tick();
        async_i[1]  = 1'b0;
        repeat (15) tick();
        check("glitch_level", 32'(level_o[1]), 32'h0);
        async_i[1] = 1'b1;
        wait_edge(1, 1'b1, 40, n);
        check("held_rise_latency", 32'(n), 32'd10);

        // Pending set, set-wins-over-clear, then clear alone.
        threshold_i   = CW'(2);
        rise_irq_en_i = 4'b0001;
        async_i[0]    = 1'b0;
        wait_edge(0, 1'b0, 40, n);
        check("ch0_fall_seen", 32'(n > 0), 32'h1);
        async_i[0] = 1'b1;
        wait_edge(0, 1'b1, 40, n);
        check("ch0_rise_seen", 32'(n > 0), 32'h1);
        tick();
        check("pend_set", 32'(pending_o[0]), 32'h1);
        check("pend_irq", 32'(irq_o),        32'h1);
        async_i[0] = 1'b0;
        wait_edge(0, 1'b0, 40, n);
        async_i[0] = 1'b1;
        wait_edge(0, 1'b1, 40, n);
        irq_clear_i = 4'b0001;
        tick();
        irq_clear_i = '0;
        check("pend_set_wins", 32'(pending_o[0]), 32'h1);
        irq_clear_i = 4'b0001;
        tick();
        irq_clear_i = '0;
        check("pend_cleared", 32'(pending_o[0]), 32'h0);
        check("irq_cleared",  32'(irq_o),        32'h0);

        // Threshold 0 behaves as 1.
        threshold_i = '0;
        async_i[2]  = 1'b1;
        wait_edge(2, 1'b1, 20, n);
        check("thr0_latency", 32'(n), 32'd3);

        // Enable dropped mid-wait: no event, count restarts from zero.
        threshold_i = CW'(10);
        async_i[3]  = 1'b1;
        repeat (5) tick();
        enable_i = 1'b0;
        repeat (3) tick();
        check("disabled_level", 32'(level_o[3]), 32'h0);
        enable_i = 1'b1;
        wait_edge(3, 1'b1, 40, n);
        check("reenable_latency", 32'(n), 32'd10);

        // Lower threshold from 100 to 3 while ch1 counts at 50.
        threshold_i = CW'(100);
        async_i[1]  = 1'b0;
        for (int k = 0; k < 200 && run_m[1] != 50; k++) tick();
        threshold_i = CW'(3);
        tick();
        check("thr_drop_fall",  32'(fall_o[1]),  32'h1);
        check("thr_drop_level", 32'(level_o[1]), 32'h0);

        // Reset in the middle of a wait aborts it; full debounce needed afterwards.
        async_i     = '0;
        threshold_i = CW'(1);
        repeat (10) tick();
        threshold_i = CW'(8);
        async_i[2]  = 1'b1;
        for (int k = 0; k < 50 && run_m[2] != 4; k++) tick();
        rst_n_i = 1'b0;
        tick();
        check("midreset_level",   32'(level_o),   32'h0);
        check("midreset_rise",    32'(rise_o),    32'h0);
        check("midreset_pending", 32'(pending_o), 32'h0);
        rst_n_i = 1'b1;
        wait_edge(2, 1'b1, 40, n);
        check("post_reset_latency", 32'(n), 32'd10);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) async_i[i] = ~async_i[i];
            end
            if ($urandom_range(0, 49) == 0) threshold_i = CW'($urandom_range(0, 6));
            enable_i    = ($urandom_range(0, 19) != 0);
            irq_clear_i = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) begin
                rise_irq_en_i = CH'($urandom);
                fall_irq_en_i = CH'($urandom);
            end
            rst_n_i = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
